// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters (MODE=1), or a static not-taken predictor (MODE=0). Also
//   resolves EX-stage branches into a mispredict/redirect and keeps
//   saturating statistics.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   if_pc               fetch PC being looked up
//   pred_taken/target   combinational prediction for if_pc (target 0 if not taken)
//   ex_valid            EX instruction is real
//   ex_is_branch        EX instruction is a branch/jump
//   ex_pc               PC of the EX instruction
//   ex_taken/target     resolved direction/target
//   ex_pred_taken/target prediction that travelled with the instruction
//   flush_all           invalidate every table entry
//   mispredict          redirect fetch (combinational)
//   redirect_pc         correct next PC when mispredict=1, else 0
//   branch_cnt          resolved-branch count (saturating)
//   mispred_cnt         mispredict count (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 8,
  parameter int MODE    = 1,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  input  logic              flush_all,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  // Flattened view of the per-entry registers for the lookup/update muxes.
  logic [ENTRIES-1:0] valid_v;
  logic [TAG_W-1:0]   tag_v    [ENTRIES];
  logic [PC_W-1:0]    target_v [ENTRIES];
  logic [1:0]         cnt_v    [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             upd_en;
  logic             lk_hit;

  // The byte offset of the fetch PC plays no part in the lookup.
  logic unused_if_lsb;
  assign unused_if_lsb = ^if_pc[1:0];

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
  assign upd_en = ex_valid && (MODE == 1);

  // ---------------------------------------------------------------------------
  // Table entries
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic             valid_q, valid_d;
      logic [TAG_W-1:0] tag_q, tag_d;
      logic [PC_W-1:0]  target_q, target_d;
      logic [1:0]       cnt_q, cnt_d;
      logic             sel;
      logic             hit;

      assign sel = upd_en && (ex_idx == IDX_W'(gi));
      assign hit = valid_q && (tag_q == ex_tag);

      always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if ((MODE == 1) && flush_all) begin
          // Flush wins over any concurrent update; only valid bits change.
          valid_d = 1'b0;
        end else if (sel) begin
          if (ex_is_branch) begin
            if (hit) begin
              if (ex_taken) begin
                cnt_d    = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
                target_d = ex_target;
              end else begin
                cnt_d    = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
              end
            end else if (ex_taken) begin
              // Allocate over whatever occupied the slot, weakly taken.
              valid_d  = 1'b1;
              tag_d    = ex_tag;
              target_d = ex_target;
              cnt_d    = 2'd2;
            end
          end else if (ex_pred_taken && hit) begin
            // A non-branch was predicted taken: the entry belongs to a
            // different instruction that aliases here, so drop it.
            valid_d = 1'b0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q  <= 1'b0;
          tag_q    <= '0;
          target_q <= '0;
          cnt_q    <= '0;
        end else begin
          valid_q  <= valid_d;
          tag_q    <= tag_d;
          target_q <= target_d;
          cnt_q    <= cnt_d;
        end
      end

      assign valid_v[gi]  = valid_q;
      assign tag_v[gi]    = tag_q;
      assign target_v[gi] = target_q;
      assign cnt_v[gi]    = cnt_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  assign lk_hit      = valid_v[if_idx] && (tag_v[if_idx] == if_tag);
  assign pred_taken  = (MODE == 1) && lk_hit && cnt_v[if_idx][1];
  assign pred_target = pred_taken ? target_v[if_idx] : '0;

  // ---------------------------------------------------------------------------
  // Resolution
  // ---------------------------------------------------------------------------
  always_comb begin
    mispredict = 1'b0;
    if (ex_valid) begin
      if (ex_is_branch)
        mispredict = (ex_taken != ex_pred_taken) ||
                     (ex_taken && (ex_target != ex_pred_target));
      else
        mispredict = ex_pred_taken;
    end
  end

  always_comb begin
    redirect_pc = '0;
    if (mispredict)
      redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + PC_W'(4);
  end

  // ---------------------------------------------------------------------------
  // Statistics (frozen during flush_all)
  // ---------------------------------------------------------------------------
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (!flush_all) begin
      if (ex_valid && ex_is_branch && (branch_cnt_q != '1))
        branch_cnt_d = branch_cnt_q + STAT_W'(1);
      if (mispredict && (mispred_cnt_q != '1))
        mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Directed vector table plus randomized traffic checked against an
//   array-based reference model. A second instance (MODE=0, STAT_W=4) sees
//   the same stimulus to cover the static predictor and counter saturation.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] if_pc;
  logic       ex_valid, ex_is_branch, ex_taken, ex_pred_taken, flush_all;
  logic [8:0] ex_pc, ex_target, ex_pred_target;

  logic        pred_taken, mispredict;
  logic [8:0]  pred_target, redirect_pc;
  logic [15:0] branch_cnt, mispred_cnt;

  logic        m0_pred_taken, m0_mispredict;
  logic [8:0]  m0_pred_target, m0_redirect_pc;
  logic [3:0]  m0_branch_cnt, m0_mispred_cnt;

  int nchecks = 0;
  int nerrs   = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush_all(flush_all), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predictor #(.MODE(0), .STAT_W(4)) dut_m0 (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(m0_pred_taken), .pred_target(m0_pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush_all(flush_all), .mispredict(m0_mispredict), .redirect_pc(m0_redirect_pc),
    .branch_cnt(m0_branch_cnt), .mispred_cnt(m0_mispred_cnt)
  );

  // ---------------------------------------------------------------------------
  // Reference model: 8 entries, PC_W=9 -> index pc[4:2], tag pc[8:5]
  // ---------------------------------------------------------------------------
  bit m_valid [8];
  int m_tag   [8];
  int m_tgt   [8];
  int m_cnt   [8];
  int m_br, m_mp;

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
    end
    m_br = 0; m_mp = 0;
  endfunction

  function automatic void m_lookup(input int pc, output bit t, output int tg);
    int i;
    i  = (pc / 4) % 8;
    t  = m_valid[i] && (m_tag[i] == pc / 32) && (m_cnt[i] >= 2);
    tg = t ? m_tgt[i] : 0;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  typedef struct {
    bit rst, ev, br;
    int epc;
    bit tk;
    int tgt;
    bit pt;
    int ptg;
    bit fl;
    int ipc;
    bit x_misp;
    int x_redir;
    bit x_pred;
    int x_ptgt;
  } vec_t;

  function automatic vec_t mk(bit rst, bit ev, bit br, int epc, bit tk, int tgt,
                              bit pt, int ptg, bit fl, int ipc,
                              bit xm, int xr, bit xp, int xt);
    vec_t v;
    v.rst = rst; v.ev = ev; v.br = br; v.epc = epc; v.tk = tk; v.tgt = tgt;
    v.pt = pt; v.ptg = ptg; v.fl = fl; v.ipc = ipc;
    v.x_misp = xm; v.x_redir = xr; v.x_pred = xp; v.x_ptgt = xt;
    return v;
  endfunction

  function automatic vec_t idle(int ipc, bit xp, int xt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ipc, 0, 0, xp, xt);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus: combinational outputs are checked before the
  // edge, registered statistics after it.
  task automatic run_cycle(input vec_t v, input bit has_exp, input string tag);
    bit e_pred, e_misp;
    int e_ptgt, e_redir, ix;
    reset = v.rst; ex_valid = v.ev; ex_is_branch = v.br; ex_pc = 9'(v.epc);
    ex_taken = v.tk; ex_target = 9'(v.tgt); ex_pred_taken = v.pt;
    ex_pred_target = 9'(v.ptg); flush_all = v.fl; if_pc = 9'(v.ipc);
    #1;
    m_lookup(v.ipc, e_pred, e_ptgt);
    e_misp  = v.ev && (v.br ? (v.tk != v.pt || (v.tk && v.tgt != v.ptg)) : v.pt);
    e_redir = !e_misp ? 0 : ((v.br && v.tk) ? v.tgt : (v.epc + 4) % 512);
    if (has_exp) begin
      chk({tag, " vec_pred"},   pred_taken,  v.x_pred);
      chk({tag, " vec_ptgt"},   pred_target, v.x_ptgt);
      chk({tag, " vec_misp"},   mispredict,  v.x_misp);
      chk({tag, " vec_redir"},  redirect_pc, v.x_redir);
    end else begin
      chk({tag, " pred"},  pred_taken,  e_pred);
      chk({tag, " ptgt"},  pred_target, e_ptgt);
      chk({tag, " misp"},  mispredict,  e_misp);
      chk({tag, " redir"}, redirect_pc, e_redir);
    end
    chk({tag, " m0_pred"},  m0_pred_taken,  0);
    chk({tag, " m0_misp"},  m0_mispredict,  e_misp);
    chk({tag, " m0_redir"}, m0_redirect_pc, e_redir);
    // Model state update.
    if (v.rst) begin
      m_reset();
    end else if (v.fl) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 0;
    end else if (v.ev) begin
      ix = (v.epc / 4) % 8;
      if (v.br) begin
        if (m_valid[ix] && m_tag[ix] == v.epc / 32) begin
          if (v.tk) begin
            m_cnt[ix] = (m_cnt[ix] < 3) ? m_cnt[ix] + 1 : 3;
            m_tgt[ix] = v.tgt;
          end else begin
            m_cnt[ix] = (m_cnt[ix] > 0) ? m_cnt[ix] - 1 : 0;
          end
        end else if (v.tk) begin
          m_valid[ix] = 1; m_tag[ix] = v.epc / 32; m_tgt[ix] = v.tgt; m_cnt[ix] = 2;
        end
      end else if (v.pt && m_valid[ix] && m_tag[ix] == v.epc / 32) begin
        m_valid[ix] = 0;
      end
      if (v.br) m_br++;
      if (e_misp) m_mp++;
    end
    @(posedge clk);
    #1;
    chk({tag, " branch_cnt"},     branch_cnt,     sat(m_br, 65535));
    chk({tag, " mispred_cnt"},    mispred_cnt,    sat(m_mp, 65535));
    chk({tag, " m0_branch_cnt"},  m0_branch_cnt,  sat(m_br, 15));
    chk({tag, " m0_mispred_cnt"}, m0_mispred_cnt, sat(m_mp, 15));
    $display("cycle %s: if_pc=%03h pred=%0d/%03h ex_pc=%03h misp=%0d redir=%03h br=%0d mp=%0d",
             tag, v.ipc, pred_taken, pred_target, v.epc, mispredict, redirect_pc,
             branch_cnt, mispred_cnt);
    @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    bit   p;
    int   pt, ix;

    // Directed vectors (expected values are hand-derived constants).
    //                 rst ev br epc    tk tgt    pt ptg    fl ipc      misp redir  pred ptgt
    vecs.push_back(mk(0, 1, 1, 'h040, 1, 'h010, 0, 'h000, 0, 'h040,  1, 'h010, 0, 'h000));
    vecs.push_back(idle('h040, 1, 'h010));
    vecs.push_back(mk(0, 1, 1, 'h040, 0, 'h000, 1, 'h010, 0, 'h040,  1, 'h044, 1, 'h010));
    vecs.push_back(idle('h040, 0, 'h000));
    vecs.push_back(mk(0, 1, 1, 'h040, 0, 'h000, 0, 'h000, 0, 'h040,  0, 'h000, 0, 'h000));
    vecs.push_back(mk(0, 1, 1, 'h040, 1, 'h010, 0, 'h000, 0, 'h040,  1, 'h010, 0, 'h000));
    vecs.push_back(mk(0, 1, 1, 'h040, 1, 'h010, 0, 'h000, 0, 'h040,  1, 'h010, 0, 'h000));
    vecs.push_back(idle('h040, 1, 'h010));
    vecs.push_back(mk(0, 1, 0, 'h040, 0, 'h000, 1, 'h010, 0, 'h040,  1, 'h044, 1, 'h010));
    vecs.push_back(idle('h040, 0, 'h000));
    vecs.push_back(mk(0, 1, 0, 'h1FC, 0, 'h000, 1, 'h000, 0, 'h1FC,  1, 'h000, 0, 'h000));
    vecs.push_back(mk(0, 1, 1, 'h040, 1, 'h020, 0, 'h000, 0, 'h040,  1, 'h020, 0, 'h000));
    vecs.push_back(idle('h040, 1, 'h020));
    vecs.push_back(mk(0, 1, 1, 'h080, 1, 'h030, 0, 'h000, 1, 'h040,  1, 'h030, 1, 'h020));
    vecs.push_back(idle('h040, 0, 'h000));
    vecs.push_back(idle('h080, 0, 'h000));
    vecs.push_back(mk(0, 1, 1, 'h100, 1, 'h0A0, 1, 'h0A4, 0, 'h100,  1, 'h0A0, 0, 'h000));
    vecs.push_back(idle('h100, 1, 'h0A0));
    vecs.push_back(mk(0, 0, 1, 'h100, 1, 'h000, 1, 'h000, 0, 'h100,  0, 'h000, 1, 'h0A0));
    vecs.push_back(mk(0, 1, 1, 'h100, 1, 'h0A0, 1, 'h0A0, 0, 'h100,  0, 'h000, 1, 'h0A0));
    vecs.push_back(mk(1, 1, 1, 'h040, 1, 'h010, 0, 'h000, 0, 'h100,  1, 'h010, 1, 'h0A0));
    vecs.push_back(idle('h040, 0, 'h000));
    vecs.push_back(idle('h100, 0, 'h000));
    vecs.push_back(mk(0, 1, 1, 'h042, 1, 'h014, 0, 'h000, 0, 'h043,  1, 'h014, 0, 'h000));
    vecs.push_back(idle('h041, 1, 'h014));

    reset = 1; ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_taken = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0; flush_all = 0; if_pc = 'h040;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pred_taken",  pred_taken,  0);
    chk("reset pred_target", pred_target, 0);
    chk("reset branch_cnt",  branch_cnt,  0);
    chk("reset mispred_cnt", mispred_cnt, 0);

    foreach (vecs[i]) run_cycle(vecs[i], 1'b1, $sformatf("dir%0d", i));

    // 20 resolved branches: the STAT_W=4 instance must stop at 15.
    run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "sat_rst");
    for (int i = 0; i < 20; i++)
      run_cycle(mk(0, 1, 1, 'h0C0 + 4 * (i % 4), 0, 0, 0, 0, 0, 'h0C0, 0, 0, 0, 0),
                1'b0, $sformatf("sat%0d", i));
    chk("sat m0_branch_cnt=15", m0_branch_cnt, 15);
    chk("sat branch_cnt=20",    branch_cnt,    20);

    // Randomized traffic over a small PC space so hits and aliases occur.
    for (int n = 0; n < 600; n++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.rst = ($urandom_range(0, 149) == 0);
      v.fl  = ($urandom_range(0, 39) == 0);
      v.ev  = ($urandom_range(0, 7) != 0);
      v.br  = ($urandom_range(0, 3) != 0);
      v.epc = 32 * $urandom_range(0, 3) + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      v.tk  = $urandom_range(0, 1);
      v.tgt = 4 * $urandom_range(0, 127);
      if (n % 16 == 15) v.epc = 'h1FC;
      m_lookup(v.epc, p, pt);
      if ($urandom_range(0, 3) != 0) begin
        v.pt = p; v.ptg = pt;
      end else begin
        v.pt = $urandom_range(0, 1); v.ptg = v.pt ? 4 * $urandom_range(0, 127) : 0;
      end
      ix = $urandom_range(0, 1);
      v.ipc = ix ? v.epc : 32 * $urandom_range(0, 3) + 4 * $urandom_range(0, 7);
      run_cycle(v, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter PC_W, default 9: width of all PC and target signals.
REQ-002 Parameter ENTRIES, default 8: number of predictor table entries; power of 2, >=2; IDX_W = log2(ENTRIES); PC_W >= IDX_W+3.
REQ-003 Parameter MODE, default 1: 0 = static not-taken, 1 = dynamic BTB with 2-bit counters.
REQ-004 Parameter STAT_W, default 16: width of the statistics counters.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 if_pc  in  PC_W  fetch-stage PC being looked up.
REQ-008 pred_taken  out  1  prediction for if_pc; combinational from the table state.
REQ-009 pred_target  out  PC_W  predicted target; 0 when pred_taken=0.
REQ-010 ex_valid  in  1  the EX-stage instruction is real (not a bubble or flushed instruction).
REQ-011 ex_is_branch  in  1  the EX instruction is a conditional branch or jump.
REQ-012 ex_pc  in  PC_W  PC of the EX instruction.
REQ-013 ex_taken  in  1  resolved direction.
REQ-014 ex_target  in  PC_W  resolved target.
REQ-015 ex_pred_taken, ex_pred_target  in  1, PC_W  prediction carried down the pipe with the instruction.
REQ-016 flush_all  in  1  invalidate the whole table (fence.i).
REQ-017 mispredict  out  1  redirect fetch and flush IF/ID and ID/EX; combinational.
REQ-018 redirect_pc  out  PC_W  correct next PC; valid when mispredict=1, 0 otherwise.
REQ-019 branch_cnt, mispred_cnt  out  STAT_W each  resolved-branch and mispredict counts.

Function
REQ-020 Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-021 Each entry holds: valid, tag, target (PC_W), and a 2-bit counter.
REQ-022 Lookup: pred_taken=1 iff MODE=1, entry valid, tag match, and counter[1]=1; pred_target = entry target.
REQ-023 Lookup is combinational on the current state; an update in cycle N is visible to lookups from cycle N+1, including same-index conflicts.
REQ-024 mispredict = ex_valid && (ex_is_branch ? (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)) : ex_pred_taken).
REQ-025 redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc+4, truncated modulo 2^PC_W.
REQ-026 Update is performed only when ex_valid=1 and MODE=1.
- Branch, hit, taken: counter +1, saturating at 3; target <= ex_target.
- Branch, hit, not taken: counter -1, saturating at 0; target kept.
- Branch, miss, taken: allocate entry (overwrite any old occupant): valid=1, new tag, target, counter=2.
- Branch, miss, not taken: no table change.
- Non-branch with ex_pred_taken=1 (alias): clear valid of the indexed entry if its tag matches.
REQ-027 When MODE=0, table state is never written; pred_taken=0; mispredict and statistics still operate.
REQ-028 branch_cnt +1 per cycle with ex_valid && ex_is_branch; mispred_cnt +1 per cycle with mispredict; both saturate at 2^STAT_W-1 and do not wrap.
REQ-029 Priority: reset > flush_all > update. flush_all clears all valid bits and leaves counters, targets and statistics unchanged; mispredict/redirect_pc remain computed during flush_all.
REQ-030 ex_valid=0: no update and no statistic change; mispredict=0.

Reset
REQ-031 On reset, all valid bits, tags, targets, and counters become 0; branch_cnt=mispred_cnt=0; pred_taken=0; pred_target=0.
REQ-032 A reset asserted mid-operation discards any update presented in that cycle; the first lookup after reset returns not-taken.

Verification
REQ-033 After reset, branch ex_pc=0x040 taken to 0x010 with ex_pred_taken=0 -> mispredict=1, redirect_pc=0x010; next cycle if_pc=0x040 -> pred_taken=1, pred_target=0x010.
REQ-034 Same branch resolved not-taken twice -> counter 2->1->0; if_pc=0x040 -> pred_taken=0 after the first resolution; second resolution with pred 0 -> mispredict=0.
REQ-035 Aliasing: ENTRIES=8, entry for 0x040 valid; non-branch ex_pc=0x040 with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x044, entry invalidated next cycle.
REQ-036 Wrap: ex_pc=0x1FC non-branch mispredicted -> redirect_pc=0x000 (PC_W=9).
REQ-037 flush_all and update asserted in the same cycle -> table all invalid afterward, mispredict still reported; MODE=0 run -> pred_taken always 0.
REQ-038 STAT_W=4: 20 resolved branches -> branch_cnt holds 15.
